// File: rtl/siganal_next_pkg.sv
// Shared widths and extMode encodings for the immediate-extension unit.
package siganal_next_pkg;

    localparam int unsigned SIGN_EXTEND_LEN = 16;
    localparam int unsigned WORD_LEN        = 32;

    localparam logic [1:0] EXT_SIGN   = 2'b00;
    localparam logic [1:0] EXT_ZERO   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

endpackage

// File: rtl/siganal_next_core.sv
// Combinational mode mux: widens the raw immediate into a datapath word.
module siganal_next_core
    import siganal_next_pkg::*;
#(
    parameter int unsigned IN_W  = SIGN_EXTEND_LEN,
    parameter int unsigned OUT_W = WORD_LEN
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       extMode,
    output logic [OUT_W-1:0] extWord
);

    logic s;
    assign s = imm[IN_W-1];

    always_comb begin
        extWord = '0;
        unique case (extMode)
            EXT_SIGN:   extWord = {{(OUT_W-IN_W){s}}, imm};
            EXT_ZERO:   extWord = {{(OUT_W-IN_W){1'b0}}, imm};
            EXT_UPPER:  extWord = {imm, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: extWord = {{(OUT_W-IN_W-2){s}}, imm, 2'b00};
            default:    extWord = '0;
        endcase
    end

endmodule

// File: rtl/siganal_next.sv
// Immediate-extension unit; define SIGNEXT_REG_OUT_EN for a 1-cycle registered output
// stage with synchronous reset, otherwise the block is purely combinational.
module siganal_next
    import siganal_next_pkg::*;
#(
    parameter int unsigned IN_W  = SIGN_EXTEND_LEN,
    parameter int unsigned OUT_W = WORD_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  inputSignalBeforeExtension,
    input  logic [1:0]       extMode,
    input  logic             validIn,
    output logic [OUT_W-1:0] outputSignalAfterExtension,
    output logic             extNegative,
    output logic             validOut
);

    logic [OUT_W-1:0] extWord;

    siganal_next_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm     (inputSignalBeforeExtension),
        .extMode (extMode),
        .extWord (extWord)
    );

`ifdef SIGNEXT_REG_OUT_EN
    logic [OUT_W-1:0] wordQ;
    logic             validQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            wordQ  <= '0;
            validQ <= 1'b0;
        end else begin
            wordQ  <= extWord;
            validQ <= validIn;
        end
    end

    assign outputSignalAfterExtension = wordQ;
    assign validOut                   = validQ;
`else
    // Clock and reset are unused in the single-cycle build.
    logic unusedClkRst;
    assign unusedClkRst = clk ^ rst;

    assign outputSignalAfterExtension = extWord;
    assign validOut                   = validIn;
`endif

    assign extNegative = outputSignalAfterExtension[OUT_W-1];

endmodule

// File: tb/tb_siganal_next.sv
// Self-checking bench for siganal_next; adapts to the SIGNEXT_REG_OUT_EN build.
module tb_siganal_next;
    import siganal_next_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] inSig = '0;
    logic [1:0]  extMode = EXT_SIGN;
    logic        validIn = 1'b0;
    logic [31:0] outWord;
    logic        extNegative;
    logic        validOut;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    siganal_next dut (
        .clk                        (clk),
        .rst                        (rst),
        .inputSignalBeforeExtension (inSig),
        .extMode                    (extMode),
        .validIn                    (validIn),
        .outputSignalAfterExtension (outWord),
        .extNegative                (extNegative),
        .validOut                   (validOut)
    );

    // Reference: numeric meaning of each format, modulo 2^32.
    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        int          sv;
        logic [31:0] r;
        sv = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
        case (mode)
            EXT_SIGN:   r = 32'(sv);
            EXT_ZERO:   r = 32'(int'(imm));
            EXT_UPPER:  r = 32'(int'(imm)) * 32'd65536;
            default:    r = 32'(sv * 4);
        endcase
        return r;
    endfunction

    task automatic drive(input logic [15:0] imm, input logic [1:0] mode, input logic v);
        @(negedge clk);
        inSig   = imm;
        extMode = mode;
        validIn = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] expW;
        logic        expV;
        rst = 1'b1;
        drive(16'h8000, EXT_SIGN, 1'b1);
`ifdef SIGNEXT_REG_OUT_EN
        expW = 32'h0;
        expV = 1'b0;
`else
        expW = model(16'h8000, EXT_SIGN);
        expV = 1'b1;
`endif
        checks++;
        if (outWord !== expW) begin
            errors++;
            $display("FAIL reset_word got=%h exp=%h", outWord, expW);
        end
        checks++;
        if (extNegative !== expW[31]) begin
            errors++;
            $display("FAIL reset_neg got=%b exp=%b", extNegative, expW[31]);
        end
        checks++;
        if (validOut !== expV) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=%b", validOut, expV);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] imms  [10] = '{16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234,
                                    16'h8001, 16'hFFFF, 16'h0001, 16'h4000, 16'h0000};
        logic [1:0]  modes [10] = '{EXT_SIGN, EXT_SIGN, EXT_ZERO, EXT_ZERO, EXT_UPPER,
                                    EXT_UPPER, EXT_BRANCH, EXT_BRANCH, EXT_BRANCH, EXT_SIGN};
        logic [31:0] exps  [10] = '{32'hFFFF8000, 32'h00007FFF, 32'h00008000, 32'h0000FFFF,
                                    32'h12340000, 32'h80010000, 32'hFFFFFFFC, 32'h00000004,
                                    32'h00010000, 32'h00000000};
        for (int i = 0; i < 10; i++) begin
            drive(imms[i], modes[i], 1'b1);
            checks++;
            if (outWord !== exps[i]) begin
                errors++;
                $display("FAIL directed_word[%0d] got=%h exp=%h", i, outWord, exps[i]);
            end
            checks++;
            if (extNegative !== exps[i][31]) begin
                errors++;
                $display("FAIL directed_neg[%0d] got=%b exp=%b", i, extNegative, exps[i][31]);
            end
            checks++;
            if (validOut !== 1'b1) begin
                errors++;
                $display("FAIL directed_valid[%0d] got=%b exp=1", i, validOut);
            end
        end
    endtask

    task automatic test_latency();
        drive(16'h0001, EXT_ZERO, 1'b0);
        @(negedge clk);
        inSig   = 16'h8000;
        extMode = EXT_SIGN;
        validIn = 1'b1;
        #1;
`ifdef SIGNEXT_REG_OUT_EN
        checks++;
        if (outWord !== 32'h00000001 || validOut !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got=%h/%b exp=00000001/0", outWord, validOut);
        end
`else
        checks++;
        if (outWord !== 32'hFFFF8000 || validOut !== 1'b1) begin
            errors++;
            $display("FAIL latency_comb got=%h/%b exp=ffff8000/1", outWord, validOut);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (outWord !== 32'hFFFF8000 || validOut !== 1'b1 || extNegative !== 1'b1) begin
            errors++;
            $display("FAIL latency_after got=%h/%b/%b exp=ffff8000/1/1",
                     outWord, validOut, extNegative);
        end
    endtask

    task automatic test_random();
        logic [15:0] imm;
        logic [1:0]  mode;
        logic        v;
        logic [31:0] expW;
        for (int i = 0; i < 300; i++) begin
            imm  = 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            v    = 1'($urandom_range(0, 1));
            drive(imm, mode, v);
            expW = model(imm, mode);
            checks++;
            if (outWord !== expW || extNegative !== expW[31] || validOut !== v) begin
                errors++;
                $display("FAIL random[%0d] imm=%h mode=%0d got=%h/%b/%b exp=%h/%b/%b", i, imm,
                         mode, outWord, extNegative, validOut, expW, expW[31], v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expQ[$];
        logic        vQ[$];
        logic [31:0] expW;
        logic        expV;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            inSig   = 16'($urandom);
            extMode = 2'($urandom_range(0, 3));
            validIn = 1'b1;
            expQ.push_back(model(inSig, extMode));
            vQ.push_back(1'b1);
            @(posedge clk);
            #1;
            expW = expQ.pop_front();
            expV = vQ.pop_front();
            checks++;
            if (outWord !== expW || validOut !== expV) begin
                errors++;
                $display("FAIL b2b[%0d] got=%h/%b exp=%h/%b", i, outWord, validOut, expW, expV);
            end
            // New input immediately after the edge: no idle cycles.
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] expW;
        logic        expV;
        for (int i = 0; i < 3; i++) drive(16'h7FFF, EXT_SIGN, 1'b1);
        rst = 1'b1;
        drive(16'h7FFF, EXT_SIGN, 1'b1);
`ifdef SIGNEXT_REG_OUT_EN
        expW = 32'h0;
        expV = 1'b0;
`else
        expW = 32'h00007FFF;
        expV = 1'b1;
`endif
        checks++;
        if (outWord !== expW || validOut !== expV || extNegative !== 1'b0) begin
            errors++;
            $display("FAIL midreset got=%h/%b/%b exp=%h/%b/0",
                     outWord, validOut, extNegative, expW, expV);
        end
        rst = 1'b0;
        drive(16'h7FFF, EXT_SIGN, 1'b1);
        checks++;
        if (outWord !== 32'h00007FFF || validOut !== 1'b1) begin
            errors++;
            $display("FAIL resume got=%h/%b exp=00007fff/1", outWord, validOut);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
